// File: rtl/turn_signal_input.sv
// Turn-lever and hazard-button front end: synchronizes and debounces the raw
// contacts, toggles hazard mode on button presses, and paces left/right requests.
module turn_signal_input #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_left,
    input  logic sw_right,
    input  logic btn_hazard,
    output logic left,
    output logic right,
    output logic tick
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    // Bit 0 = left, bit 1 = right, bit 2 = hazard.
    logic [2:0]    raw;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    db;
    logic [CW-1:0] cnt [3];
    logic          hz_d;
    logic          hz_rise;
    logic          hazard_on;
    logic [TW-1:0] tick_cnt;

    assign raw     = {btn_hazard, sw_right, sw_left};
    assign hz_rise = db[2] & ~hz_d;
    assign tick    = (tick_cnt == TICK_LAST);

    // Two-flop synchronizer for all three raw contacts.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Per-input debouncer: level only accepted after an unbroken run of disagreement.
    always_ff @(posedge clk) begin
        if (reset) begin
            db <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Hazard mode flips on each debounced press; releases are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            hz_d      <= 1'b0;
            hazard_on <= 1'b0;
        end else begin
            hz_d <= db[2];
            if (hz_rise) begin
                hazard_on <= ~hazard_on;
            end
        end
    end

    // Free-running pacing counter; tick is decoded from its terminal value.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Requests update only on tick edges, using the hazard state before any toggle.
    always_ff @(posedge clk) begin
        if (reset) begin
            left  <= 1'b0;
            right <= 1'b0;
        end else if (tick) begin
            left  <= db[0] | hazard_on;
            right <= db[1] | hazard_on;
        end
    end

endmodule

// File: tb/tb_turn_signal_input.sv
// Scoreboard bench for turn_signal_input: windows of stimulus aligned to the
// tick period push the expected {left,right}; a monitor checks on every tick.
module tb_turn_signal_input;

    logic clk        = 1'b0;
    logic reset      = 1'b1;
    logic sw_left    = 1'b0;
    logic sw_right   = 1'b0;
    logic btn_hazard = 1'b0;
    logic left;
    logic right;
    logic tick;

    int         vecs     = 0;
    int         errs     = 0;
    int         cyc      = 0;
    bit         started  = 1'b0;
    logic [1:0] q[$];
    logic [1:0] last_exp = 2'b00;
    logic [1:0] e;

    turn_signal_input #(
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw_left(sw_left),
        .sw_right(sw_right),
        .btn_hazard(btn_hazard),
        .left(left),
        .right(right),
        .tick(tick)
    );

    always #5 clk = ~clk;

    // Bench-side cycle count since the last reset edge.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Monitor: tick pacing, output hold between ticks, and scoreboard pop after each tick.
    always @(negedge clk) begin
        if (reset) begin
            last_exp = 2'b00;
        end else if (started) begin
            vecs++;
            if (tick !== (cyc % 8 == 7)) begin
                errs++;
                $display("FAIL tick_timing cyc=%0d: got %b want %b", cyc, tick, (cyc % 8 == 7));
            end
            vecs++;
            if ({left, right} !== last_exp) begin
                errs++;
                $display("FAIL hold cyc=%0d: got %b want %b", cyc, {left, right}, last_exp);
            end
            if (tick) begin
                @(posedge clk);
                #2;
                vecs++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_tick: got tick with no expectation queued, want none");
                end else begin
                    e = q.pop_front();
                    if ({left, right} !== e) begin
                        errs++;
                        $display("FAIL tick_out: got %b want %b", {left, right}, e);
                    end
                    last_exp = e;
                end
            end
        end
    end

    // One tick window: inputs {L,R,H} = a for the first sw cycles, then b.
    task automatic win(input logic [2:0] a, input int sw,
                       input logic [2:0] b, input logic [1:0] exp_out);
        q.push_back(exp_out);
        for (int i = 0; i < 8; i++) begin
            {sw_left, sw_right, btn_hazard} = (i < sw) ? a : b;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        started = 1'b1;
        vecs++;
        if ({left, right} !== 2'b00) begin
            errs++;
            $display("FAIL reset_out: got %b want 00", {left, right});
        end

        win(3'b000, 8, 3'b000, 2'b00);  // idle
        win(3'b000, 8, 3'b000, 2'b00);
        win(3'b100, 3, 3'b000, 2'b00);  // 3-cycle glitch rejected
        win(3'b100, 8, 3'b100, 2'b10);  // left held
        win(3'b100, 8, 3'b100, 2'b10);
        win(3'b100, 8, 3'b100, 2'b10);
        win(3'b000, 8, 3'b000, 2'b00);  // left released
        win(3'b010, 8, 3'b010, 2'b01);  // right
        win(3'b000, 8, 3'b000, 2'b00);  // right released
        win(3'b110, 8, 3'b110, 2'b11);  // both, no priority
        win(3'b000, 8, 3'b000, 2'b00);
        win(3'b001, 8, 3'b001, 2'b11);  // hazard press on
        win(3'b001, 2, 3'b000, 2'b11);  // release ignored
        win(3'b100, 8, 3'b100, 2'b11);  // hazard overrides switches
        win(3'b101, 8, 3'b101, 2'b10);  // second press: off, follows left
        win(3'b101, 2, 3'b100, 2'b10);
        win(3'b000, 8, 3'b000, 2'b00);
        win(3'b000, 1, 3'b001, 2'b00);  // toggle lands on tick edge: old value used
        win(3'b001, 3, 3'b000, 2'b11);  // hazard now on
        win(3'b000, 5, 3'b100, 2'b11);  // left stable 3 cycles, then reset

        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        vecs++;
        if ({left, right} !== 2'b00) begin
            errs++;
            $display("FAIL midreset_out: got %b want 00", {left, right});
        end

        win(3'b100, 8, 3'b100, 2'b10);  // fresh debounce, hazard cleared
        win(3'b000, 8, 3'b000, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL pending: got %0d queued want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
